m2_block_writer: RTL and testbench
==================================

// Module: m2_block_writer
// PURPOSE
//  Writer end of the 8x8-block SRAM interface. The fetch side reads a block of S' words from SRAM into a dual-port RAM.
//  This block does the reverse: it drains one finished 8x8 block of 32-bit signed S values from a dual-port RAM.
//  It clips each value to 8 bits, packs two pixels per 16-bit word and writes 32 words into the SRAM image plane at (block_row, block_col).
//  The milestone-2 controller invokes it once per block with a start/done handshake.
// PARAMETERS
//  BASE_ADDR   18'd0   SRAM word address of pixel (0,0) of the target plane
//  ROW_WORDS   160     SRAM words per image row (320 px / 2)
// PORTS
//  Clock            in   1   system clock, all logic on rising edge
//  Reset            in   1   synchronous, active-high reset
//  start            in   1   one-cycle request; accepted only in S_BW_IDLE
//  block_row        in   5   block row index 0..29, sampled when start is accepted
//  block_col        in   6   block column index 0..39, sampled when start is accepted
//  dp_address_a     out  7   DPRAM port-a read address (even pixel)
//  dp_address_b     out  7   DPRAM port-b read address (odd pixel)
//  dp_q_a           in   32  DPRAM port-a data, valid one clock after the address edge
//  dp_q_b           in   32  DPRAM port-b data, valid one clock after the address edge
//  SRAM_address     out  18  SRAM word address
//  SRAM_write_data  out  16  packed pixels {even[7:0], odd[7:0]}
//  SRAM_we_n        out  1   SRAM write enable, active low
//  busy             out  1   high from the accepting edge until done is asserted
//  done             out  1   one-cycle completion pulse
// BEHAVIOUR
//  Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, busy=0, done=0, dp_address_a/b=0, state S_BW_IDLE.
//  Reset mid-operation abandons the block. SRAM_we_n is 1 on the following cycle and no partial word is completed.
//  DPRAM layout: pixel (r,p) is at address r*8+p, r,p = 0..7.
//  For word (r,c), c = 0..3: port a reads r*8+2c and port b reads r*8+2c+1.
//  SRAM address of word (r,c) = BASE_ADDR + (block_row*8+r)*ROW_WORDS + block_col*4 + c, computed modulo 2^18.
//  Clip rule per 32-bit signed value v:
//    v<0 -> 8'h00
//    v>255 -> 8'hFF
//    otherwise v[7:0]
//  States:
//    S_BW_IDLE: wait for start. On start, latch block_row/block_col, busy<=1, issue the DPRAM address for word (0,0), go to S_BW_LEAD_IN.
//    S_BW_LEAD_IN (1 cycle): issue the address for word (0,1); no SRAM write. Go to S_BW_WRITE.
//    S_BW_WRITE (32 cycles): each edge registers the clipped/packed word, its SRAM_address and SRAM_we_n=0. The address pipeline runs 2 words ahead.
//      Order: c fastest, then r. After word (7,3) is registered, go to S_BW_DONE.
//    S_BW_DONE (1 cycle): SRAM_we_n<=1, done<=1, busy<=0. Return to S_BW_IDLE. start is ignored in this cycle.
//  Latency: start is accepted at edge E. Writes are visible after edges E+2..E+33. done is high after edge E+34 for exactly one cycle.
//  start while busy or in S_BW_DONE is ignored. block_row/block_col changes after acceptance have no effect.
//  DPRAM reads past word (7,3) during drain are don't-care and are never written.
//  Arithmetic:
//    row term: 8-bit (block_row*8+r) times ROW_WORDS
//    column term: (block_col*4+c)
//    sum: 18 bits, truncated
// STRUCTURE
//  Shared package/defs header additions:
//    m2_block_writer_state_type (S_BW_IDLE, S_BW_LEAD_IN, S_BW_WRITE, S_BW_DONE)
//    PIXEL_MAX = 8'd255
//  One combinational sub-module, pixel_clip8 (32-bit signed in, 8-bit out), instantiated twice.
//  Word counter: 5 bits, word index w = 0..31, with r = w[4:2] and c = w[1:0].
// TESTING
//  1 All 64 DPRAM = 32'd128, block (0,0).
//    -> 32 writes of 16'h8080 at addresses 0..3, 160..163, ..., 1120..1123.
//    -> done exactly 34 cycles after start.
//  2 Clipping, with pixel values set as follows:
//    p0=-5, p1=300 -> 16'h00FF
//    p2=255, p3=0 -> 16'hFF00
//    p4=32'h8000_0000, p5=32'h7FFF_FFFF -> 16'h00FF
//  3 Block (29,39), BASE_ADDR 0: first write address 37276, last 38399; no write outside the block footprint.
//  4 Hold start high and toggle block_row/col during busy.
//    -> exactly one 32-word burst to the originally latched block.
//    -> start during S_BW_DONE is ignored; a new burst begins only on the next cycle.
//  5 Assert Reset during the 10th write.
//    -> next cycle SRAM_we_n=1, busy=0, done=0.
//    -> a subsequent start produces a full, correct 32-word burst.
//  6 Two back-to-back blocks (0,0) then (0,1) with distinct ramp data.
//    -> the second burst writes addresses 4..7 etc., and pixel ordering (even in [15:8]) matches the golden model.

Source files
------------

// File: rtl/m2_block_writer_pkg.sv
// rtl/m2_block_writer_pkg.sv - shared types and constants for the 8x8 block writer
package m2_block_writer_pkg;

  typedef enum logic [1:0] {
    S_BW_IDLE,
    S_BW_LEAD_IN,
    S_BW_WRITE,
    S_BW_DONE
  } m2_block_writer_state_type;

  localparam logic [7:0] PIXEL_MAX = 8'd255;

  // Even pixel of word w sits at DPRAM address r*8 + 2c, i.e. {w, 1'b0}.
  function automatic logic [6:0] word_addr_even(input logic [4:0] w);
    return {1'b0, w, 1'b0};
  endfunction

endpackage

// File: rtl/m2_block_writer_clip.sv
// rtl/m2_block_writer_clip.sv - clamp a signed 32-bit sample to an unsigned 8-bit pixel
module pixel_clip8
  import m2_block_writer_pkg::*;
(
  input  logic signed [31:0] pixel_in,
  output logic [7:0]         pixel_out
);

  always_comb begin
    if (pixel_in[31]) begin
      pixel_out = 8'h00;
    end else if (|pixel_in[30:8]) begin
      pixel_out = PIXEL_MAX;
    end else begin
      pixel_out = pixel_in[7:0];
    end
  end

endmodule

// File: rtl/m2_block_writer.sv
// rtl/m2_block_writer.sv - drains one 8x8 block from DPRAM, clips, packs and writes 32 SRAM words
module m2_block_writer
  import m2_block_writer_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR = 18'd0,
  parameter int          ROW_WORDS = 160
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [6:0]  dp_address_a,
  output logic [6:0]  dp_address_b,
  input  logic [31:0] dp_q_a,
  input  logic [31:0] dp_q_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  localparam logic [17:0] ROW_WORDS_W = 18'(ROW_WORDS);

  m2_block_writer_state_type state_q, state_d;
  logic [4:0]  w_q, w_d;
  logic [4:0]  blk_row_q, blk_row_d;
  logic [5:0]  blk_col_q, blk_col_d;
  logic [6:0]  dp_a_q, dp_a_d;
  logic [6:0]  dp_b_q, dp_b_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_data_q, sram_data_d;
  logic        we_n_q, we_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  clip_a, clip_b;
  logic [7:0]  row_term, col_term;
  logic [17:0] wr_addr;
  logic [4:0]  issue_w;

  pixel_clip8 u_clip_a (.pixel_in(dp_q_a), .pixel_out(clip_a));
  pixel_clip8 u_clip_b (.pixel_in(dp_q_b), .pixel_out(clip_b));

  assign row_term = {blk_row_q, w_q[4:2]};
  assign col_term = {blk_col_q, w_q[1:0]};
  assign wr_addr  = BASE_ADDR + 18'(row_term) * ROW_WORDS_W + 18'(col_term);
  // DPRAM data lags its address by one clock, so reads run two words ahead of writes.
  assign issue_w  = w_q + 5'd2;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    blk_row_d   = blk_row_q;
    blk_col_d   = blk_col_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    we_n_d      = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_BW_IDLE: begin
        if (start) begin
          blk_row_d = block_row;
          blk_col_d = block_col;
          busy_d    = 1'b1;
          w_d       = 5'd0;
          dp_a_d    = word_addr_even(5'd0);
          dp_b_d    = word_addr_even(5'd0) | 7'd1;
          state_d   = S_BW_LEAD_IN;
        end
      end
      S_BW_LEAD_IN: begin
        dp_a_d  = word_addr_even(5'd1);
        dp_b_d  = word_addr_even(5'd1) | 7'd1;
        state_d = S_BW_WRITE;
      end
      S_BW_WRITE: begin
        sram_addr_d = wr_addr;
        sram_data_d = {clip_a, clip_b};
        we_n_d      = 1'b0;
        dp_a_d      = word_addr_even(issue_w);
        dp_b_d      = word_addr_even(issue_w) | 7'd1;
        w_d         = w_q + 5'd1;
        if (w_q == 5'd31) begin
          state_d = S_BW_DONE;
        end
      end
      S_BW_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_BW_IDLE;
      end
      default: state_d = S_BW_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_BW_IDLE;
      w_q         <= 5'd0;
      blk_row_q   <= 5'd0;
      blk_col_q   <= 6'd0;
      dp_a_q      <= 7'd0;
      dp_b_q      <= 7'd0;
      sram_addr_q <= 18'd0;
      sram_data_q <= 16'd0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      blk_row_q   <= blk_row_d;
      blk_col_q   <= blk_col_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dp_address_a    = dp_a_q;
  assign dp_address_b    = dp_b_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_data_q;
  assign SRAM_we_n       = we_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_m2_block_writer.sv
// tb/tb_m2_block_writer.sv - directed self-checking bench for m2_block_writer
module tb_m2_block_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [6:0]  dp_address_a, dp_address_b;
  logic [31:0] dp_q_a, dp_q_b;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, busy, done;

  logic [31:0] mem [0:127];
  logic [17:0] cap_addr [$];
  logic [15:0] cap_data [$];
  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  m2_block_writer dut (
    .Clock(clk), .Reset(rst), .start(start), .block_row(block_row), .block_col(block_col),
    .dp_address_a(dp_address_a), .dp_address_b(dp_address_b), .dp_q_a(dp_q_a), .dp_q_b(dp_q_b),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    dp_q_a <= mem[dp_address_a];
    dp_q_b <= mem[dp_address_b];
  end

  always @(negedge clk) begin
    if (SRAM_we_n === 1'b0) begin
      cap_addr.push_back(SRAM_address);
      cap_data.push_back(SRAM_write_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clip(input logic [31:0] v);
    if ($signed(v) < 0) return 8'h00;
    if ($signed(v) > 255) return 8'hFF;
    return v[7:0];
  endfunction

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic issue(input logic [4:0] r, input logic [5:0] c);
    block_row = r;
    block_col = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic check_burst(input string tag, input logic [4:0] br, input logic [5:0] bc);
    chk($sformatf("%s_count", tag), cap_addr.size(), 32);
    if (cap_addr.size() == 32) begin
      for (int w = 0; w < 32; w++) begin
        int r;
        int c;
        logic [17:0] ea;
        logic [15:0] ed;
        r  = w / 4;
        c  = w % 4;
        ea = 18'((int'(br) * 8 + r) * 160 + int'(bc) * 4 + c);
        ed = {clip(mem[r*8+2*c]), clip(mem[r*8+2*c+1])};
        chk($sformatf("%s_addr_w%0d", tag, w), cap_addr[w], ea);
        chk($sformatf("%s_data_w%0d", tag, w), cap_data[w], ed);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; block_row = '0; block_col = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_n", SRAM_we_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", SRAM_address, 18'd0);
    chk("rst_data", SRAM_write_data, 16'd0);
    chk("rst_dpa", dp_address_a, 7'd0);
    chk("rst_dpb", dp_address_b, 7'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: flat mid-grey block at (0,0)
    for (int i = 0; i < 128; i++) mem[i] = 32'd128;
    clear_cap();
    issue(5'd0, 6'd0);
    chk("t1_busy_on", busy, 1'b1);
    wait_done(n);
    chk("t1_latency", n, 34);
    chk("t1_busy_off", busy, 1'b0);
    check_burst("t1", 5'd0, 6'd0);
    if (cap_addr.size() == 32) begin
      chk("t1_addr4", cap_addr[4], 18'd160);
      chk("t1_addr31", cap_addr[31], 18'd1123);
      chk("t1_data0", cap_data[0], 16'h8080);
    end
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_we_idle", SRAM_we_n, 1'b1);

    // 2: clipping corners
    for (int i = 0; i < 128; i++) mem[i] = 32'd100;
    mem[0] = 32'hFFFF_FFFB; mem[1] = 32'd300;
    mem[2] = 32'd255;       mem[3] = 32'd0;
    mem[4] = 32'h8000_0000; mem[5] = 32'h7FFF_FFFF;
    clear_cap();
    issue(5'd0, 6'd0);
    wait_done(n);
    chk("t2_latency", n, 34);
    if (cap_data.size() >= 3) begin
      chk("t2_clip_w0", cap_data[0], 16'h00FF);
      chk("t2_clip_w1", cap_data[1], 16'hFF00);
      chk("t2_clip_w2", cap_data[2], 16'h00FF);
    end
    check_burst("t2", 5'd0, 6'd0);

    // 3: bottom-right block
    for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
    clear_cap();
    issue(5'd29, 6'd39);
    wait_done(n);
    chk("t3_latency", n, 34);
    if (cap_addr.size() == 32) begin
      chk("t3_first", cap_addr[0], 18'd37276);
      chk("t3_last", cap_addr[31], 18'd38399);
    end
    check_burst("t3", 5'd29, 6'd39);

    // 4: start held high, block coordinates churn while busy
    for (int i = 0; i < 64; i++) mem[i] = 32'(250 - i);
    clear_cap();
    block_row = 5'd3; block_col = 6'd5; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      block_row = 5'(n);
      block_col = 6'(n + 7);
      @(posedge clk); #1;
      n++;
    end
    chk("t4_latency", n, 34);
    chk("t4_busy_in_done", busy, 1'b0);
    check_burst("t4", 5'd3, 6'd5);
    block_row = 5'd1; block_col = 6'd2;
    clear_cap();
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_rearm_busy", busy, 1'b1);
    chk("t4_rearm_done", done, 1'b0);
    wait_done(n);
    chk("t4b_latency", n, 34);
    check_burst("t4b", 5'd1, 6'd2);

    // 5: reset during the 10th write
    clear_cap();
    issue(5'd2, 6'd3);
    repeat (11) begin
      @(posedge clk); #1;
    end
    chk("t5_w10_we", SRAM_we_n, 1'b0);
    chk("t5_w10_addr", SRAM_address, 18'd2893);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_we", SRAM_we_n, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    clear_cap();
    issue(5'd2, 6'd3);
    wait_done(n);
    chk("t5_latency", n, 34);
    check_burst("t5", 5'd2, 6'd3);

    // 6: back-to-back blocks (0,0) then (0,1)
    for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
    clear_cap();
    issue(5'd0, 6'd0);
    wait_done(n);
    chk("t6a_latency", n, 34);
    if (cap_data.size() > 0) chk("t6a_data0", cap_data[0], 16'h0003);
    check_burst("t6a", 5'd0, 6'd0);
    for (int i = 0; i < 64; i++) mem[i] = 32'(200 - i * 3);
    clear_cap();
    issue(5'd0, 6'd1);
    wait_done(n);
    chk("t6b_latency", n, 34);
    if (cap_addr.size() == 32) begin
      chk("t6b_addr0", cap_addr[0], 18'd4);
      chk("t6b_addr4", cap_addr[4], 18'd164);
      chk("t6b_data0", cap_data[0], 16'hC8C5);
      chk("t6b_data1", cap_data[1], 16'hC2BF);
    end
    check_burst("t6b", 5'd0, 6'd1);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
